hs32_sram_arbiter: RTL and testbench

//  Sits between the HS32 core / management Wishbone and one 32-bit SRAM macro port
//  (sky130 1rw1r, port 0). Arbitrates CPU and Wishbone requests, sequences each

---
 rtl/hs32_sram_arbiter.sv | 164 ++++++++++++++++
 tb/tb_hs32_sram_arbiter.sv | 536 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hs32_sram_arbiter.sv
// Shares port 0 of one sky130 1rw1r SRAM macro between the HS32 core and the management
// Wishbone; every access runs one four-cycle IDLE/ACCESS/CAPTURE/RESP sequence.
module hs32_sram_arbiter #(
    parameter int unsigned ADDR_W  = 8,
    parameter logic [31:0] WB_BASE = 32'h3000_0000,
    parameter logic [31:0] WB_MASK = 32'hFFFF_FC00
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    input  logic              wbs_we_i,
    input  logic [3:0]        wbs_sel_i,
    input  logic [31:0]       wbs_adr_i,
    input  logic [31:0]       wbs_dat_i,
    output logic              wbs_ack_o,
    output logic [31:0]       wbs_dat_o,
    input  logic              cpu_stb_i,
    input  logic              cpu_rw_i,
    input  logic [31:0]       cpu_addr_i,
    input  logic [31:0]       cpu_dtw_i,
    input  logic [3:0]        cpu_mask_i,
    output logic              cpu_ack_o,
    output logic [31:0]       cpu_dtr_o,
    output logic              sram_csb_o,
    output logic              sram_web_o,
    output logic [3:0]        sram_wmask_o,
    output logic [ADDR_W-1:0] sram_addr_o,
    output logic [31:0]       sram_din_o,
    input  logic [31:0]       sram_dout_i,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_RESP    = 2'd3
    } state_t;

    state_t state_q, state_d;

    // Handshake: a master raises its strobe and holds it (with address/data stable) until
    // it sees a one-cycle ack; the request is sampled once, at the grant in IDLE.
    logic              wb_req, cpu_req, any_req, grant_cpu;
    logic              sel_we;
    logic [3:0]        sel_mask;
    logic [ADDR_W-1:0] sel_addr;
    logic [31:0]       sel_din;

    logic              last_grant_cpu_q, last_grant_cpu_d;
    logic              lat_cpu_q, lat_cpu_d;
    logic              lat_we_q, lat_we_d;

    logic              csb_d, web_d, cpu_ack_d, wbs_ack_d;
    logic [3:0]        wmask_d;
    logic [ADDR_W-1:0] addr_d;
    logic [31:0]       din_d, cpu_dtr_d, wbs_dat_d;

    logic              unused_addr_bits;

    assign wb_req  = wbs_cyc_i & wbs_stb_i & ((wbs_adr_i & WB_MASK) == WB_BASE);
    assign cpu_req = cpu_stb_i;
    assign any_req = wb_req | cpu_req;

    // On contention the master that did not win the previous grant goes first.
    assign grant_cpu = cpu_req & (~wb_req | ~last_grant_cpu_q);

    assign sel_we   = grant_cpu ? cpu_rw_i : wbs_we_i;
    assign sel_mask = grant_cpu ? cpu_mask_i : wbs_sel_i;
    assign sel_addr = grant_cpu ? cpu_addr_i[ADDR_W+1:2] : wbs_adr_i[ADDR_W+1:2];
    assign sel_din  = grant_cpu ? cpu_dtw_i : wbs_dat_i;

    assign unused_addr_bits = ^{cpu_addr_i[31:ADDR_W+2], cpu_addr_i[1:0], wbs_adr_i[1:0]};

    assign dbg_state = state_q;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (any_req) state_d = ST_ACCESS;
            ST_ACCESS:  state_d = ST_CAPTURE;
            ST_CAPTURE: state_d = ST_RESP;
            ST_RESP:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Outputs are computed for the state being entered so that every port is a flop.
    always_comb begin
        csb_d            = 1'b1;
        web_d            = 1'b1;
        wmask_d          = 4'h0;
        addr_d           = sram_addr_o;
        din_d            = sram_din_o;
        cpu_ack_d        = 1'b0;
        wbs_ack_d        = 1'b0;
        cpu_dtr_d        = cpu_dtr_o;
        wbs_dat_d        = wbs_dat_o;
        lat_cpu_d        = lat_cpu_q;
        lat_we_d         = lat_we_q;
        last_grant_cpu_d = last_grant_cpu_q;
        if (state_q == ST_IDLE && state_d == ST_ACCESS) begin
            csb_d            = 1'b0;
            web_d            = ~sel_we;
            wmask_d          = sel_we ? sel_mask : 4'h0;
            addr_d           = sel_addr;
            din_d            = sel_din;
            lat_cpu_d        = grant_cpu;
            lat_we_d         = sel_we;
            last_grant_cpu_d = grant_cpu;
        end
        if (state_q == ST_CAPTURE) begin
            if (!lat_we_q) begin
                if (lat_cpu_q) begin
                    cpu_dtr_d = sram_dout_i;
                end else begin
                    wbs_dat_d = sram_dout_i;
                end
            end
            cpu_ack_d = lat_cpu_q;
            wbs_ack_d = ~lat_cpu_q;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            sram_csb_o       <= 1'b1;
            sram_web_o       <= 1'b1;
            sram_wmask_o     <= 4'h0;
            sram_addr_o      <= '0;
            sram_din_o       <= 32'h0;
            cpu_ack_o        <= 1'b0;
            wbs_ack_o        <= 1'b0;
            cpu_dtr_o        <= 32'h0;
            wbs_dat_o        <= 32'h0;
            lat_cpu_q        <= 1'b0;
            lat_we_q         <= 1'b0;
            last_grant_cpu_q <= 1'b0;
        end else begin
            sram_csb_o       <= csb_d;
            sram_web_o       <= web_d;
            sram_wmask_o     <= wmask_d;
            sram_addr_o      <= addr_d;
            sram_din_o       <= din_d;
            cpu_ack_o        <= cpu_ack_d;
            wbs_ack_o        <= wbs_ack_d;
            cpu_dtr_o        <= cpu_dtr_d;
            wbs_dat_o        <= wbs_dat_d;
            lat_cpu_q        <= lat_cpu_d;
            lat_we_q         <= lat_we_d;
            last_grant_cpu_q <= last_grant_cpu_d;
        end
    end

endmodule

// File: tb/tb_hs32_sram_arbiter.sv
// Bench for hs32_sram_arbiter: behavioural SRAM macro, word-level memory reference model,
// round-robin grant model and latency expectations derived from the four-cycle sequence.
module tb_hs32_sram_arbiter;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wbs_cyc = 1'b0, wbs_stb = 1'b0, wbs_we = 1'b0;
    logic [3:0]  wbs_sel = 4'h0;
    logic [31:0] wbs_adr = 32'h0, wbs_dat_w = 32'h0;
    logic        wbs_ack;
    logic [31:0] wbs_dat_r;
    logic        cpu_stb = 1'b0, cpu_rw = 1'b0;
    logic [31:0] cpu_addr = 32'h0, cpu_dtw = 32'h0;
    logic [3:0]  cpu_mask = 4'h0;
    logic        cpu_ack;
    logic [31:0] cpu_dtr;
    logic        sram_csb, sram_web;
    logic [3:0]  sram_wmask;
    logic [7:0]  sram_addr;
    logic [31:0] sram_din;
    logic [31:0] sram_dout = 32'h0;
    logic [1:0]  dbg_state;

    int          n_vec = 0;
    int          n_err = 0;

    logic [31:0] ref_mem [256];
    logic        model_last_cpu;
    logic [31:0] exp_cpu_dtr, exp_wb_dat;
    logic [31:0] exp_q[$];

    logic [31:0] sram_mem [256];
    int          acc_count = 0;
    logic [7:0]  acc_addr = 8'h0;
    logic        acc_web = 1'b1;
    logic [3:0]  acc_wmask = 4'h0;
    logic [31:0] acc_din = 32'h0;

    hs32_sram_arbiter dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .wbs_cyc_i   (wbs_cyc),
        .wbs_stb_i   (wbs_stb),
        .wbs_we_i    (wbs_we),
        .wbs_sel_i   (wbs_sel),
        .wbs_adr_i   (wbs_adr),
        .wbs_dat_i   (wbs_dat_w),
        .wbs_ack_o   (wbs_ack),
        .wbs_dat_o   (wbs_dat_r),
        .cpu_stb_i   (cpu_stb),
        .cpu_rw_i    (cpu_rw),
        .cpu_addr_i  (cpu_addr),
        .cpu_dtw_i   (cpu_dtw),
        .cpu_mask_i  (cpu_mask),
        .cpu_ack_o   (cpu_ack),
        .cpu_dtr_o   (cpu_dtr),
        .sram_csb_o  (sram_csb),
        .sram_web_o  (sram_web),
        .sram_wmask_o(sram_wmask),
        .sram_addr_o (sram_addr),
        .sram_din_o  (sram_din),
        .sram_dout_i (sram_dout),
        .dbg_state   (dbg_state)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] m);
        merge = old_w;
        for (int b = 0; b < 4; b++) begin
            if (m[b]) merge[8*b +: 8] = new_w[8*b +: 8];
        end
    endfunction

    // SRAM macro port 0: access on csb=0 at the clock edge, read data the following cycle.
    always @(posedge clk) begin
        if (!sram_csb) begin
            acc_count <= acc_count + 1;
            acc_addr  <= sram_addr;
            acc_web   <= sram_web;
            acc_wmask <= sram_wmask;
            acc_din   <= sram_din;
            if (!sram_web) begin
                sram_mem[sram_addr] <= merge(sram_mem[sram_addr], sram_din, sram_wmask);
            end else begin
                sram_dout <= sram_mem[sram_addr];
            end
        end
    end

    // Reference: predicts the data output seen with the ack and updates the memory image.
    task automatic model_txn(input logic is_cpu, input logic rw, input logic [7:0] w,
                             input logic [31:0] d, input logic [3:0] m, output logic [31:0] exp_rd);
        if (rw) begin
            ref_mem[w] = merge(ref_mem[w], d, m);
            exp_rd = is_cpu ? exp_cpu_dtr : exp_wb_dat;
        end else begin
            exp_rd = ref_mem[w];
            if (is_cpu) exp_cpu_dtr = exp_rd;
            else        exp_wb_dat  = exp_rd;
        end
        model_last_cpu = is_cpu;
    endtask

    task automatic model_reset();
        model_last_cpu = 1'b0;
        exp_cpu_dtr    = 32'h0;
        exp_wb_dat     = 32'h0;
    endtask

    task automatic cpu_txn(input logic rw, input logic [31:0] addr, input logic [31:0] d,
                           input logic [3:0] m, output int lat, output logic [31:0] rd);
        lat = -1;
        rd  = 32'h0;
        @(negedge clk);
        cpu_stb = 1'b1; cpu_rw = rw; cpu_addr = addr; cpu_dtw = d; cpu_mask = m;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (cpu_ack) begin
                lat = i;
                rd  = cpu_dtr;
                break;
            end
        end
        cpu_stb = 1'b0;
    endtask

    task automatic wb_txn(input logic rw, input logic [31:0] addr, input logic [31:0] d,
                          input logic [3:0] m, output int lat, output logic [31:0] rd);
        lat = -1;
        rd  = 32'h0;
        @(negedge clk);
        wbs_cyc = 1'b1; wbs_stb = 1'b1; wbs_we = rw; wbs_adr = addr; wbs_dat_w = d; wbs_sel = m;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (wbs_ack) begin
                lat = i;
                rd  = wbs_dat_r;
                break;
            end
        end
        wbs_cyc = 1'b0; wbs_stb = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_vec++;
        if ({sram_csb, sram_web, sram_wmask, sram_addr, sram_din} !== {1'b1, 1'b1, 4'h0, 8'h00, 32'h0}) begin
            n_err++;
            $display("FAIL reset_sram got csb=%b web=%b wmask=%h addr=%h din=%h want 1 1 0 00 00000000",
                     sram_csb, sram_web, sram_wmask, sram_addr, sram_din);
        end
        n_vec++;
        if ({cpu_ack, wbs_ack, cpu_dtr, wbs_dat_r} !== {2'b00, 64'h0}) begin
            n_err++;
            $display("FAIL reset_outputs got acks=%b%b cpu_dtr=%h wbs_dat=%h want 00 0 0",
                     cpu_ack, wbs_ack, cpu_dtr, wbs_dat_r);
        end
        n_vec++;
        if (dbg_state !== ST_IDLE) begin
            n_err++;
            $display("FAIL reset_state got %0d want %0d", dbg_state, ST_IDLE);
        end
        rst = 1'b0;
        model_reset();
    endtask

    // Loads every word with a known value, alternating the two masters.
    task automatic test_fill();
        int lat;
        logic [31:0] rd, exp_rd, d;
        for (int w = 0; w < 256; w++) begin
            d = $urandom;
            if (w[0]) wb_txn(1'b1, 32'h3000_0000 | 32'(w * 4), d, 4'hF, lat, rd);
            else      cpu_txn(1'b1, 32'(w * 4), d, 4'hF, lat, rd);
            model_txn(~w[0], 1'b1, 8'(w), d, 4'hF, exp_rd);
            n_vec++;
            if (lat !== 3 || rd !== exp_rd) begin
                n_err++;
                $display("FAIL fill_w%0d got lat=%0d rd=%h want lat=3 rd=%h", w, lat, rd, exp_rd);
            end
        end
    endtask

    task automatic test_cpu_basic();
        int lat, a0;
        logic [31:0] rd, exp_rd;
        a0 = acc_count;
        cpu_txn(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, lat, rd);
        model_txn(1'b1, 1'b1, 8'd4, 32'hDEAD_BEEF, 4'hF, exp_rd);
        n_vec++;
        if (lat !== 3) begin n_err++; $display("FAIL cpu_wr_latency got %0d want 3", lat); end
        n_vec++;
        if (acc_count - a0 !== 1) begin n_err++; $display("FAIL cpu_wr_csb_cycles got %0d want 1", acc_count - a0); end
        n_vec++;
        if ({acc_addr, acc_web, acc_wmask, acc_din} !== {8'd4, 1'b0, 4'hF, 32'hDEAD_BEEF}) begin
            n_err++;
            $display("FAIL cpu_wr_strobe got addr=%h web=%b wmask=%h din=%h want 04 0 f deadbeef",
                     acc_addr, acc_web, acc_wmask, acc_din);
        end
        n_vec++;
        if (rd !== exp_rd) begin n_err++; $display("FAIL cpu_wr_dtr_held got %h want %h", rd, exp_rd); end
        @(negedge clk);
        n_vec++;
        if (cpu_ack !== 1'b0) begin n_err++; $display("FAIL cpu_ack_width got %b want 0", cpu_ack); end
        cpu_txn(1'b0, 32'h10, 32'h0, 4'h0, lat, rd);
        model_txn(1'b1, 1'b0, 8'd4, 32'h0, 4'h0, exp_rd);
        n_vec++;
        if (lat !== 3 || rd !== 32'hDEAD_BEEF || rd !== exp_rd) begin
            n_err++;
            $display("FAIL cpu_rd got lat=%0d rd=%h want lat=3 rd=%h", lat, rd, exp_rd);
        end
        n_vec++;
        if ({acc_web, acc_wmask} !== {1'b1, 4'h0}) begin
            n_err++;
            $display("FAIL cpu_rd_strobe got web=%b wmask=%h want 1 0", acc_web, acc_wmask);
        end
    endtask

    task automatic test_wb_partial();
        int lat;
        logic [31:0] rd, exp_rd;
        cpu_txn(1'b1, 32'h20, 32'hDEAD_BEEF, 4'hF, lat, rd);
        model_txn(1'b1, 1'b1, 8'd8, 32'hDEAD_BEEF, 4'hF, exp_rd);
        wb_txn(1'b1, 32'h3000_0020, 32'h1234_5678, 4'b0011, lat, rd);
        model_txn(1'b0, 1'b1, 8'd8, 32'h1234_5678, 4'b0011, exp_rd);
        n_vec++;
        if (lat !== 3 || rd !== exp_rd) begin
            n_err++;
            $display("FAIL wb_wr got lat=%0d dat=%h want lat=3 dat=%h", lat, rd, exp_rd);
        end
        wb_txn(1'b0, 32'h3000_0020, 32'h0, 4'h0, lat, rd);
        model_txn(1'b0, 1'b0, 8'd8, 32'h0, 4'h0, exp_rd);
        n_vec++;
        if (lat !== 3 || rd !== 32'hDEAD_5678 || rd !== exp_rd) begin
            n_err++;
            $display("FAIL wb_rd_merge got lat=%0d dat=%h want lat=3 dat=dead5678", lat, rd);
        end
        n_vec++;
        if (cpu_dtr !== exp_cpu_dtr) begin
            n_err++;
            $display("FAIL cpu_dtr_untouched got %h want %h", cpu_dtr, exp_cpu_dtr);
        end
    endtask

    task automatic test_arbitration();
        int cpu_lat, wb_lat, lat, a0;
        logic [31:0] cpu_rd, wb_rd, exp_c, exp_w, rd, exp_rd, cd, wd;
        logic cpu_rw_r, wb_rw_r, cpu_first, solo_cpu;
        logic [7:0] cw, ww;
        logic [3:0] cm, wm;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int r = 0; r < 10; r++) begin
            if (r == 2 || (r > 3 && $urandom_range(1, 0) == 1)) begin
                solo_cpu = 1'($urandom_range(1, 0));
                cw = 8'($urandom_range(255, 0));
                if (solo_cpu) cpu_txn(1'b0, {22'd0, cw, 2'b00}, 32'h0, 4'h0, lat, rd);
                else          wb_txn(1'b0, 32'h3000_0000 | {22'd0, cw, 2'b00}, 32'h0, 4'h0, lat, rd);
                model_txn(solo_cpu, 1'b0, cw, 32'h0, 4'h0, exp_rd);
                n_vec++;
                if (lat !== 3 || rd !== exp_rd) begin
                    n_err++;
                    $display("FAIL arb_solo_r%0d got lat=%0d rd=%h want lat=3 rd=%h", r, lat, rd, exp_rd);
                end
            end
            cpu_rw_r = 1'($urandom_range(1, 0)); wb_rw_r = 1'($urandom_range(1, 0));
            cw = 8'($urandom_range(127, 0));     ww = 8'($urandom_range(255, 128));
            cd = $urandom;                       wd = $urandom;
            cm = 4'($urandom_range(15, 0));      wm = 4'($urandom_range(15, 0));
            cpu_first = ~model_last_cpu;
            if (cpu_first) begin
                model_txn(1'b1, cpu_rw_r, cw, cd, cm, exp_c);
                model_txn(1'b0, wb_rw_r, ww, wd, wm, exp_w);
            end else begin
                model_txn(1'b0, wb_rw_r, ww, wd, wm, exp_w);
                model_txn(1'b1, cpu_rw_r, cw, cd, cm, exp_c);
            end
            a0 = acc_count;
            cpu_lat = -1; wb_lat = -1; cpu_rd = 32'h0; wb_rd = 32'h0;
            @(negedge clk);
            cpu_stb = 1'b1; cpu_rw = cpu_rw_r; cpu_addr = {22'd0, cw, 2'b00}; cpu_dtw = cd; cpu_mask = cm;
            wbs_cyc = 1'b1; wbs_stb = 1'b1; wbs_we = wb_rw_r;
            wbs_adr = 32'h3000_0000 | {22'd0, ww, 2'b00}; wbs_dat_w = wd; wbs_sel = wm;
            for (int i = 1; i <= 16; i++) begin
                @(negedge clk);
                if (cpu_stb && cpu_ack) begin cpu_lat = i; cpu_rd = cpu_dtr; cpu_stb = 1'b0; end
                if (wbs_stb && wbs_ack) begin wb_lat = i; wb_rd = wbs_dat_r; wbs_stb = 1'b0; wbs_cyc = 1'b0; end
                if (!cpu_stb && !wbs_stb) break;
            end
            cpu_stb = 1'b0; wbs_stb = 1'b0; wbs_cyc = 1'b0;
            n_vec++;
            if (cpu_lat !== (cpu_first ? 3 : 7) || wb_lat !== (cpu_first ? 7 : 3)) begin
                n_err++;
                $display("FAIL arb_order_r%0d got cpu_lat=%0d wb_lat=%0d want %0d %0d", r, cpu_lat, wb_lat,
                         cpu_first ? 3 : 7, cpu_first ? 7 : 3);
            end
            n_vec++;
            if (cpu_rd !== exp_c || wb_rd !== exp_w) begin
                n_err++;
                $display("FAIL arb_data_r%0d got cpu=%h wb=%h want cpu=%h wb=%h", r, cpu_rd, wb_rd, exp_c, exp_w);
            end
            n_vec++;
            if (acc_count - a0 !== 2) begin
                n_err++;
                $display("FAIL arb_csb_r%0d got %0d accesses want 2", r, acc_count - a0);
            end
        end
    endtask

    task automatic test_wb_miss();
        logic [31:0] addrs [4];
        logic cyc_v [4];
        int acks, a0;
        addrs[0] = 32'h3000_1000; cyc_v[0] = 1'b1;
        addrs[1] = 32'h3000_0400; cyc_v[1] = 1'b1;
        addrs[2] = 32'h2000_0010; cyc_v[2] = 1'b1;
        addrs[3] = 32'h3000_0010; cyc_v[3] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            a0 = acc_count;
            acks = 0;
            @(negedge clk);
            wbs_cyc = cyc_v[k]; wbs_stb = 1'b1; wbs_we = 1'b1; wbs_adr = addrs[k];
            wbs_dat_w = 32'hFFFF_FFFF; wbs_sel = 4'hF;
            repeat (20) begin
                @(negedge clk);
                if (wbs_ack || cpu_ack) acks++;
            end
            wbs_cyc = 1'b0; wbs_stb = 1'b0;
            n_vec++;
            if (acks !== 0 || acc_count - a0 !== 0) begin
                n_err++;
                $display("FAIL wb_miss_%0d adr=%h got acks=%0d accesses=%0d want 0 0", k, addrs[k], acks, acc_count - a0);
            end
        end
    endtask

    task automatic test_reset_mid();
        int acks, a0, lat;
        logic [31:0] rd, exp_rd;
        @(negedge clk);
        cpu_stb = 1'b1; cpu_rw = 1'b0; cpu_addr = 32'h10;
        @(negedge clk);
        n_vec++;
        if ({sram_csb, dbg_state} !== {1'b0, ST_ACCESS}) begin
            n_err++;
            $display("FAIL rst_mid_access got csb=%b state=%0d want 0 %0d", sram_csb, dbg_state, ST_ACCESS);
        end
        rst = 1'b1; cpu_stb = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({sram_csb, dbg_state, cpu_ack, wbs_ack, cpu_dtr} !== {1'b1, ST_IDLE, 2'b00, 32'h0}) begin
            n_err++;
            $display("FAIL rst_mid_state got csb=%b state=%0d acks=%b%b dtr=%h want 1 %0d 00 0",
                     sram_csb, dbg_state, cpu_ack, wbs_ack, cpu_dtr, ST_IDLE);
        end
        rst = 1'b0;
        model_reset();
        acks = 0;
        a0 = acc_count;
        repeat (10) begin
            @(negedge clk);
            if (cpu_ack || wbs_ack) acks++;
        end
        n_vec++;
        if (acks !== 0 || acc_count - a0 !== 0) begin
            n_err++;
            $display("FAIL rst_mid_no_ack got acks=%0d accesses=%0d want 0 0", acks, acc_count - a0);
        end
        a0 = acc_count;
        acks = 0;
        @(negedge clk);
        cpu_stb = 1'b1; cpu_rw = 1'b1; cpu_addr = 32'h14; cpu_dtw = ~ref_mem[5]; cpu_mask = 4'hF; rst = 1'b1;
        @(negedge clk);
        cpu_stb = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (cpu_ack || wbs_ack) acks++;
        end
        n_vec++;
        if (acks !== 0 || acc_count - a0 !== 0) begin
            n_err++;
            $display("FAIL rst_grant_suppressed got acks=%0d accesses=%0d want 0 0", acks, acc_count - a0);
        end
        cpu_txn(1'b0, 32'h14, 32'h0, 4'h0, lat, rd);
        model_txn(1'b1, 1'b0, 8'd5, 32'h0, 4'h0, exp_rd);
        n_vec++;
        if (lat !== 3 || rd !== exp_rd) begin
            n_err++;
            $display("FAIL rst_word_intact got lat=%0d rd=%h want lat=3 rd=%h", lat, rd, exp_rd);
        end
    endtask

    task automatic test_drop_mid();
        int acks, ack_at, a0;
        logic [31:0] rd, exp_rd;
        for (int k = 0; k < 2; k++) begin
            a0 = acc_count; acks = 0; ack_at = -1; rd = 32'h0;
            @(negedge clk);
            if (k == 0) begin
                cpu_stb = 1'b1; cpu_rw = 1'b0; cpu_addr = 32'h1C;
            end else begin
                wbs_cyc = 1'b1; wbs_stb = 1'b1; wbs_we = 1'b0; wbs_adr = 32'h3000_001C;
            end
            @(negedge clk);
            cpu_stb = 1'b0; wbs_cyc = 1'b0; wbs_stb = 1'b0;
            for (int i = 2; i <= 10; i++) begin
                @(negedge clk);
                if (cpu_ack || wbs_ack) begin
                    acks++;
                    if (ack_at < 0) ack_at = i;
                    rd = (k == 0) ? cpu_dtr : wbs_dat_r;
                end
            end
            model_txn(k == 0, 1'b0, 8'd7, 32'h0, 4'h0, exp_rd);
            n_vec++;
            if (acks !== 1 || ack_at !== 3 || rd !== exp_rd || acc_count - a0 !== 1) begin
                n_err++;
                $display("FAIL drop_mid_%0d got acks=%0d at=%0d rd=%h accesses=%0d want 1 3 %h 1",
                         k, acks, ack_at, rd, acc_count - a0, exp_rd);
            end
        end
    endtask

    task automatic test_boundary();
        int lat, a0;
        logic [31:0] rd, exp_rd, x, y;
        x = $urandom;
        y = $urandom;
        cpu_txn(1'b1, 32'h3FC, x, 4'hF, lat, rd);
        model_txn(1'b1, 1'b1, 8'd255, x, 4'hF, exp_rd);
        n_vec++;
        if (lat !== 3 || acc_addr !== 8'd255) begin
            n_err++;
            $display("FAIL top_word_wr got lat=%0d addr=%h want 3 ff", lat, acc_addr);
        end
        wb_txn(1'b0, 32'h3000_03FC, 32'h0, 4'h0, lat, rd);
        model_txn(1'b0, 1'b0, 8'd255, 32'h0, 4'h0, exp_rd);
        n_vec++;
        if (lat !== 3 || rd !== x || rd !== exp_rd) begin
            n_err++;
            $display("FAIL top_word_wb_rd got lat=%0d rd=%h want 3 %h", lat, rd, x);
        end
        cpu_txn(1'b1, 32'h400, y, 4'hF, lat, rd);
        model_txn(1'b1, 1'b1, 8'd0, y, 4'hF, exp_rd);
        n_vec++;
        if (lat !== 3 || acc_addr !== 8'd0) begin
            n_err++;
            $display("FAIL wrap_0x400 got lat=%0d addr=%h want 3 00", lat, acc_addr);
        end
        cpu_txn(1'b0, 32'h0, 32'h0, 4'h0, lat, rd);
        model_txn(1'b1, 1'b0, 8'd0, 32'h0, 4'h0, exp_rd);
        n_vec++;
        if (rd !== y || rd !== exp_rd) begin
            n_err++;
            $display("FAIL wrap_rd got %h want %h", rd, y);
        end
        a0 = acc_count;
        cpu_txn(1'b1, 32'h3FC, ~x, 4'h0, lat, rd);
        model_txn(1'b1, 1'b1, 8'd255, ~x, 4'h0, exp_rd);
        n_vec++;
        if (lat !== 3 || acc_count - a0 !== 1 || {acc_web, acc_wmask} !== {1'b0, 4'h0}) begin
            n_err++;
            $display("FAIL mask0_wr got lat=%0d accesses=%0d web=%b wmask=%h want 3 1 0 0",
                     lat, acc_count - a0, acc_web, acc_wmask);
        end
        cpu_txn(1'b0, 32'h3FC, 32'h0, 4'h0, lat, rd);
        model_txn(1'b1, 1'b0, 8'd255, 32'h0, 4'h0, exp_rd);
        n_vec++;
        if (rd !== x || rd !== exp_rd) begin
            n_err++;
            $display("FAIL mask0_unchanged got %h want %h", rd, x);
        end
    endtask

    task automatic test_random();
        int lat;
        logic [31:0] rd, exp_rd, a, d;
        logic is_cpu, rw;
        logic [7:0] w;
        logic [3:0] m;
        for (int t = 0; t < 40; t++) begin
            is_cpu = 1'($urandom_range(1, 0));
            rw     = 1'($urandom_range(1, 0));
            w      = 8'($urandom_range(255, 0));
            m      = 4'($urandom_range(15, 0));
            d      = $urandom;
            a      = $urandom;
            a[9:2] = w;
            if (is_cpu) cpu_txn(rw, a, d, m, lat, rd);
            else        wb_txn(rw, 32'h3000_0000 | {22'd0, w, 2'(a[1:0])}, d, m, lat, rd);
            model_txn(is_cpu, rw, w, d, m, exp_rd);
            exp_q.push_back(exp_rd);
            n_vec++;
            if (lat !== 3) begin n_err++; $display("FAIL rand_lat_%0d got %0d want 3", t, lat); end
            n_vec++;
            if (rd !== exp_q[0]) begin
                n_err++;
                $display("FAIL rand_data_%0d cpu=%b rw=%b w=%h got %h want %h", t, is_cpu, rw, w, rd, exp_q[0]);
            end
            void'(exp_q.pop_front());
            n_vec++;
            if (cpu_dtr !== exp_cpu_dtr || wbs_dat_r !== exp_wb_dat) begin
                n_err++;
                $display("FAIL rand_hold_%0d got cpu=%h wb=%h want cpu=%h wb=%h", t, cpu_dtr, wbs_dat_r,
                         exp_cpu_dtr, exp_wb_dat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_cpu_basic();
        test_wb_partial();
        test_arbitration();
        test_wb_miss();
        test_reset_mid();
        test_drop_mid();
        test_boundary();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
